// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter giving N_REQ ATM front-ends serialized access to one balance register.
// Optional ATM_WITHDRAW_LIMIT_EN adds a cumulative withdrawal ceiling with limit_clear.
module atm_account_arbiter #(
  parameter int                 N_REQ        = 2,
  parameter int                 BAL_W        = 32,
  parameter int                 AMT_W        = 16,
  parameter logic [BAL_W-1:0]   INIT_BALANCE = 32'h000F4240
`ifdef ATM_WITHDRAW_LIMIT_EN
  ,
  parameter logic [AMT_W-1:0]   WD_LIMIT     = 16'd5000
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [AMT_W*N_REQ-1:0] amount,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   ok,
  output logic [BAL_W-1:0]       balance_out,
  output logic                   busy
`ifdef ATM_WITHDRAW_LIMIT_EN
  ,
  input  logic                   limit_clear
`endif
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_READ     = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_WITHDRAW = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_EXEC, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  sel_q;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] amt_q;
  logic [BAL_W-1:0] bal_q;
  logic [BAL_W-1:0] bal_out_q;
  logic             ok_q;

  logic             pick_vld;
  logic [ID_W-1:0]  pick_id;
  logic             exec_ok;
  logic [BAL_W-1:0] exec_bal;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W:0]   dep_sum;

`ifdef ATM_WITHDRAW_LIMIT_EN
  logic [AMT_W:0]   wd_total_q, wd_total_d;
  logic [AMT_W:0]   wd_sum;
`endif

  // Wrapping scan upward from rr_ptr: the first asserted request wins.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(idx);
      end
    end
  end

  // Deposit overflow is the carry out of a BAL_W+1-bit sum.
  function automatic logic deposit_ovf(input logic [BAL_W:0] sum);
    return sum[BAL_W];
  endfunction

  always_comb begin
    amt_ext  = BAL_W'(amt_q);
    dep_sum  = {1'b0, bal_q} + {1'b0, amt_ext};
    exec_ok  = 1'b0;
    exec_bal = bal_q;
`ifdef ATM_WITHDRAW_LIMIT_EN
    wd_sum   = wd_total_q + {1'b0, amt_q};
`endif
    case (op_q)
      OP_READ: exec_ok = 1'b1;
      OP_DEPOSIT: begin
        if (!deposit_ovf(dep_sum)) begin
          exec_ok  = 1'b1;
          exec_bal = dep_sum[BAL_W-1:0];
        end
      end
      OP_WITHDRAW: begin
`ifdef ATM_WITHDRAW_LIMIT_EN
        if (amt_ext <= bal_q && wd_sum <= {1'b0, WD_LIMIT}) begin
`else
        if (amt_ext <= bal_q) begin
`endif
          exec_ok  = 1'b1;
          exec_bal = bal_q - amt_ext;
        end
      end
      default: exec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: if (|req) state_d = S_SEL;
      S_SEL: begin
        if (pick_vld) begin
          state_d  = S_EXEC;
          rr_ptr_d = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + 1'b1;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_EXEC:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ATM_WITHDRAW_LIMIT_EN
  // A coincident clear takes priority over accumulating an accepted withdrawal.
  always_comb begin
    wd_total_d = wd_total_q;
    if (limit_clear)
      wd_total_d = '0;
    else if (state_q == S_EXEC && op_q == OP_WITHDRAW && exec_ok)
      wd_total_d = wd_sum;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_total_q <= '0;
    else       wd_total_q <= wd_total_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      bal_q     <= INIT_BALANCE;
      bal_out_q <= INIT_BALANCE;
      ok_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (state_q == S_EXEC) begin
        bal_q     <= exec_bal;
        bal_out_q <= exec_bal;
        ok_q      <= exec_ok;
      end
    end
  end

  // Captured transaction fields; only meaningful from EXEC onward.
  always_ff @(posedge clk) begin
    if (state_q == S_SEL && pick_vld) begin
      sel_q <= pick_id;
      op_q  <= op[2*pick_id +: 2];
      amt_q <= amount[AMT_W*pick_id +: AMT_W];
    end
  end

  always_comb begin
    grant = '0;
    done  = '0;
    busy  = (state_q != S_IDLE);
    ok    = (state_q == S_RESP) && ok_q;
    if (state_q == S_EXEC) grant[sel_q] = 1'b1;
    if (state_q == S_RESP) done[sel_q]  = 1'b1;
  end

  assign balance_out = bal_out_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed self-checking bench for atm_account_arbiter; three instances cover different reset balances.
module tb_atm_account_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        limit_clear;
  logic [1:0]  req   [3];
  logic [3:0]  op    [3];
  logic [31:0] amt   [3];
  logic [1:0]  grant [3];
  logic [1:0]  done  [3];
  logic        ok    [3];
  logic [31:0] bal   [3];
  logic        busy  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  atm_account_arbiter #(.INIT_BALANCE(32'h000F4240)) u_dut (
    .clk(clk), .reset(reset), .req(req[0]), .op(op[0]), .amount(amt[0]),
    .grant(grant[0]), .done(done[0]), .ok(ok[0]), .balance_out(bal[0]), .busy(busy[0])
`ifdef ATM_WITHDRAW_LIMIT_EN
    , .limit_clear(limit_clear)
`endif
  );

  atm_account_arbiter #(.INIT_BALANCE(32'd100)) u_small (
    .clk(clk), .reset(reset), .req(req[1]), .op(op[1]), .amount(amt[1]),
    .grant(grant[1]), .done(done[1]), .ok(ok[1]), .balance_out(bal[1]), .busy(busy[1])
`ifdef ATM_WITHDRAW_LIMIT_EN
    , .limit_clear(limit_clear)
`endif
  );

  atm_account_arbiter #(.INIT_BALANCE(32'hFFFFFFF0)) u_big (
    .clk(clk), .reset(reset), .req(req[2]), .op(op[2]), .amount(amt[2]),
    .grant(grant[2]), .done(done[2]), .ok(ok[2]), .balance_out(bal[2]), .busy(busy[2])
`ifdef ATM_WITHDRAW_LIMIT_EN
    , .limit_clear(limit_clear)
`endif
  );

  // One full transaction on instance k from front-end id; expects grant at cycle 2, done at cycle 3.
  task automatic txn(input int k, input int id, input logic [1:0] opc, input logic [15:0] a,
                     input logic exp_ok, input logic [31:0] exp_bal, input string name);
    int          gcyc;
    int          dcyc;
    logic        got_ok;
    logic [31:0] got_bal;
    gcyc = 0; dcyc = 0; got_ok = 1'bx; got_bal = 'x;
    @(negedge clk);
    op[k][2*id +: 2]   = opc;
    amt[k][16*id +: 16] = a;
    req[k][id]         = 1'b1;
    for (int n = 1; n <= 12 && dcyc == 0; n++) begin
      @(negedge clk);
      if (grant[k][id]) gcyc = n;
      if (done[k][id]) begin
        dcyc    = n;
        got_ok  = ok[k];
        got_bal = bal[k];
      end
    end
    req[k][id] = 1'b0;
    checks++;
    if (dcyc !== 3) begin errors++; $display("FAIL %s done_cycle got %0d want 3", name, dcyc); end
    checks++;
    if (gcyc !== 2) begin errors++; $display("FAIL %s grant_cycle got %0d want 2", name, gcyc); end
    checks++;
    if (got_ok !== exp_ok) begin errors++; $display("FAIL %s ok got %b want %b", name, got_ok, exp_ok); end
    checks++;
    if (got_bal !== exp_bal) begin errors++; $display("FAIL %s balance got %0d want %0d", name, got_bal, exp_bal); end
  endtask

  task automatic test_reset();
    logic [31:0] init_v [3];
    init_v[0] = 32'd1000000; init_v[1] = 32'd100; init_v[2] = 32'hFFFFFFF0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (grant[k] !== 2'b00 || done[k] !== 2'b00) begin
        errors++; $display("FAIL reset_grant_done[%0d] got %b/%b want 00/00", k, grant[k], done[k]);
      end
      checks++;
      if (ok[k] !== 1'b0 || busy[k] !== 1'b0) begin
        errors++; $display("FAIL reset_ok_busy[%0d] got %b/%b want 0/0", k, ok[k], busy[k]);
      end
      checks++;
      if (bal[k] !== init_v[k]) begin
        errors++; $display("FAIL reset_balance[%0d] got %0d want %0d", k, bal[k], init_v[k]);
      end
    end
  endtask

  task automatic test_fairness();
    int   order [4];
    int   cnt;
    int   want;
    logic all_ok;
    cnt = 0; all_ok = 1'b1;
    @(negedge clk);
    op[0]  = 4'b0000;
    req[0] = 2'b11;
    for (int n = 0; n < 40 && cnt < 4; n++) begin
      @(negedge clk);
      if (done[0] == 2'b01 || done[0] == 2'b10) begin
        order[cnt] = (done[0] == 2'b01) ? 0 : 1;
        if (ok[0] !== 1'b1 || bal[0] !== 32'd1000000) all_ok = 1'b0;
        cnt++;
      end else if (done[0] != 2'b00) begin
        all_ok = 1'b0;
      end
    end
    req[0] = 2'b00;
    checks++;
    if (cnt !== 4) begin errors++; $display("FAIL fair_count got %0d want 4", cnt); end
    for (int i = 0; i < cnt; i++) begin
      want = i % 2;
      checks++;
      if (order[i] !== want) begin errors++; $display("FAIL fair_order[%0d] got %0d want %0d", i, order[i], want); end
    end
    checks++;
    if (all_ok !== 1'b1) begin errors++; $display("FAIL fair_responses got %b want 1", all_ok); end
  endtask

  task automatic test_read_deposit();
    txn(0, 0, 2'b00, 16'd0,   1'b1, 32'd1000000, "read0");
    txn(0, 1, 2'b01, 16'd500, 1'b1, 32'd1000500, "deposit500");
    txn(0, 0, 2'b00, 16'd0,   1'b1, 32'd1000500, "read_after_dep");
  endtask

  task automatic test_withdraw();
    txn(1, 0, 2'b10, 16'd101, 1'b0, 32'd100, "wd_overdraft");
    txn(1, 0, 2'b10, 16'd100, 1'b1, 32'd0,   "wd_exact");
    txn(1, 1, 2'b10, 16'd0,   1'b1, 32'd0,   "wd_zero");
    txn(1, 1, 2'b01, 16'd0,   1'b1, 32'd0,   "dep_zero");
  endtask

  task automatic test_overflow();
    txn(2, 0, 2'b01, 16'h0020, 1'b0, 32'hFFFFFFF0, "dep_overflow");
    txn(2, 1, 2'b11, 16'h0005, 1'b0, 32'hFFFFFFF0, "op_invalid");
    txn(2, 1, 2'b01, 16'h000F, 1'b1, 32'hFFFFFFFF, "dep_to_max");
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    op[0][1:0]  = 2'b10;
    amt[0][15:0] = 16'd300;
    req[0][0]   = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (grant[0] !== 2'b01) begin errors++; $display("FAIL mid_exec_grant got %b want 01", grant[0]); end
    reset = 1'b1;
    #1;
    checks++;
    if (bal[0] !== 32'd1000000 || done[0] !== 2'b00 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state got bal=%0d done=%b busy=%b want 1000000/00/0", bal[0], done[0], busy[0]);
    end
    req[0][0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done[0] != 2'b00) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin errors++; $display("FAIL mid_reset_no_done got %b want 0", seen_done); end
    txn(0, 0, 2'b00, 16'd0, 1'b1, 32'd1000000, "read_after_abort");
  endtask

`ifdef ATM_WITHDRAW_LIMIT_EN
  task automatic test_limit();
    txn(0, 0, 2'b10, 16'd4000, 1'b1, 32'd996000, "lim_wd4000");
    txn(0, 0, 2'b10, 16'd1001, 1'b0, 32'd996000, "lim_wd1001_rej");
    @(negedge clk);
    limit_clear = 1'b1;
    @(negedge clk);
    limit_clear = 1'b0;
    txn(0, 1, 2'b10, 16'd1001, 1'b1, 32'd994999, "lim_wd1001_after_clr");
  endtask
`endif

  initial begin
    reset = 1'b1;
    limit_clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = '0;
      op[k]  = '0;
      amt[k] = '0;
    end
    test_reset();
    test_fairness();
    test_read_deposit();
    test_withdraw();
    test_overflow();
    test_reset_mid();
`ifdef ATM_WITHDRAW_LIMIT_EN
    test_limit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
